// File: rtl/cp_ex_param.sv
// cp_ex_param: parametrised CP execute stage (ALU, predicates, MSL, iterative MUL).
// Define CP_EX_MULH_EN for a 2*DATA_WIDTH accumulator and opcode 111 as MULHU.
module cp_ex_param #(
  parameter int DATA_WIDTH = 32,
  parameter int PRED_NUM = 4,
  parameter int RF_INDEX_WIDTH = 5,
  parameter int PC_WIDTH = 30,
  parameter int MUL_BITS_PER_CYCLE = 1,
  localparam int PSW = (PRED_NUM > 1) ? $clog2(PRED_NUM) : 1
) (
  input  logic                      iClk,
  input  logic                      iReset_n,
  input  logic                      iID_EX_Valid,
  output logic                      oEX_ID_Stall,
  input  logic [3:0]                iID_EX_ALU_Opcode,
  input  logic [DATA_WIDTH-1:0]     iID_EX_ALU_Operand_A,
  input  logic [DATA_WIDTH-1:0]     iID_EX_ALU_Operand_B,
  input  logic [PRED_NUM-1:0]       iID_EX_Pred_Write_Mask,
  input  logic [PSW-1:0]            iID_EX_CMOV_Pred_Sel,
  input  logic [2:0]                iID_EX_MSL_Opcode,
  input  logic [DATA_WIDTH-1:0]     iID_EX_MSL_Operand_A,
  input  logic [DATA_WIDTH-1:0]     iID_EX_MSL_Operand_B,
  input  logic [2:0]                iID_EX_RF_WriteBack,
  input  logic [RF_INDEX_WIDTH-1:0] iID_EX_RF_Write_Addr,
  input  logic [PC_WIDTH-1:0]       iID_EX_PC,
  input  logic [DATA_WIDTH-1:0]     iDMEM_EX_Data,
  output logic [PRED_NUM-1:0]       oEX_ID_Pred,
  output logic [DATA_WIDTH-1:0]     oEX_WB_Write_RF_Data,
  output logic [RF_INDEX_WIDTH-1:0] oEX_WB_Write_RF_Address,
  output logic                      oEX_WB_Write_RF_Enable
);

  localparam int K = DATA_WIDTH / MUL_BITS_PER_CYCLE;
  localparam int CW = $clog2(K + 1);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int LW = (PC_WIDTH + 2 > DATA_WIDTH) ? PC_WIDTH + 2 : DATA_WIDTH;
`ifdef CP_EX_MULH_EN
  localparam int AW = 2 * DATA_WIDTH;
`else
  localparam int AW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_n;
  logic [AW-1:0] acc, mcand, partial;
  logic [DATA_WIDTH-1:0] mplier, mul_res;
  logic [CW-1:0] count;
  logic [RF_INDEX_WIDTH-1:0] mul_addr;
  logic mul_we;
`ifdef CP_EX_MULH_EN
  logic mul_hi;
`endif
  logic [PRED_NUM-1:0] pred_q, pred_we, pred_n;

  logic [2:0] aop, mop;
  logic uns, is_cmp, lt, eq, flag, active;
  logic [DATA_WIDTH:0] ext_a, ext_b, diff;
  logic [DATA_WIDTH-1:0] alu_res, msl_res, lr, wb_mux;
  logic [DATA_WIDTH-1:0] sh_a;
  logic [SHW-1:0] sh_amt;
  logic is_shift, is_mul, launch;
  logic [LW-1:0] lr_full;

  assign aop = iID_EX_ALU_Opcode[2:0];
  assign uns = iID_EX_ALU_Opcode[3];
  assign mop = iID_EX_MSL_Opcode;
  assign active = iID_EX_Valid & (state == S_IDLE);

  // One extended subtractor: top bit is less-than, low bits the zero test
  assign ext_a = {~uns & iID_EX_ALU_Operand_A[DATA_WIDTH-1], iID_EX_ALU_Operand_A};
  assign ext_b = {~uns & iID_EX_ALU_Operand_B[DATA_WIDTH-1], iID_EX_ALU_Operand_B};
  assign diff = ext_a + ~ext_b + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign lt = diff[DATA_WIDTH];
  assign eq = (diff[DATA_WIDTH-1:0] == '0);
  assign is_cmp = aop[2] | aop[1];

  always_comb begin
    flag = 1'b0;
    case (aop)
      3'b010: flag = eq;
      3'b011: flag = ~eq;
      3'b100: flag = lt | eq;
      3'b101: flag = lt;
      3'b110: flag = ~lt;
      3'b111: flag = ~(lt | eq);
      default: flag = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (aop)
      3'b000: alu_res = uns ? (pred_q[iID_EX_CMOV_Pred_Sel] ?
                               iID_EX_ALU_Operand_A : iID_EX_ALU_Operand_B)
                            : iID_EX_ALU_Operand_A + iID_EX_ALU_Operand_B;
      3'b001: alu_res = diff[DATA_WIDTH-1:0];
      default: alu_res = {{(DATA_WIDTH-1){1'b0}}, flag};
    endcase
  end

  assign pred_we = {PRED_NUM{active & is_cmp}} & iID_EX_Pred_Write_Mask;
  assign pred_n = (pred_we & {PRED_NUM{flag}}) | (~pred_we & pred_q);
  assign oEX_ID_Pred = pred_n;

  assign is_shift = (mop == 3'b011) | (mop == 3'b100) | (mop == 3'b101);
  assign sh_a = iID_EX_MSL_Operand_A & {DATA_WIDTH{is_shift}};
  assign sh_amt = iID_EX_MSL_Operand_B[SHW-1:0] & {SHW{is_shift}};
`ifdef CP_EX_MULH_EN
  assign is_mul = (mop == 3'b110) | (mop == 3'b111);
`else
  assign is_mul = (mop == 3'b110);
`endif
  assign launch = active & is_mul & (iID_EX_RF_WriteBack[2:1] == 2'b11);

  always_comb begin
    msl_res = '0;
    case (mop)
      3'b000: msl_res = iID_EX_MSL_Operand_A & iID_EX_MSL_Operand_B;
      3'b001: msl_res = iID_EX_MSL_Operand_A | iID_EX_MSL_Operand_B;
      3'b010: msl_res = iID_EX_MSL_Operand_A ^ iID_EX_MSL_Operand_B;
      3'b011: msl_res = sh_a << sh_amt;
      3'b100: msl_res = sh_a >> sh_amt;
      3'b101: msl_res = $signed(sh_a) >>> sh_amt;
`ifndef CP_EX_MULH_EN
      3'b111: msl_res = iID_EX_MSL_Operand_A & iID_EX_MSL_Operand_B;
`endif
      default: msl_res = '0;
    endcase
  end

  assign lr_full = LW'({iID_EX_PC, 2'b00}) + LW'(8);
  assign lr = lr_full[DATA_WIDTH-1:0];

  always_comb begin
    wb_mux = alu_res;
    case (iID_EX_RF_WriteBack[2:1])
      2'b00: wb_mux = alu_res;
      2'b01: wb_mux = lr;
      2'b10: wb_mux = iDMEM_EX_Data;
      default: wb_mux = msl_res;
    endcase
  end

  // Radix-2^M step: add the shifted multiplicand for each retired multiplier bit
  always_comb begin
    partial = '0;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++)
      if (mplier[j]) partial = partial + (mcand << j);
  end

`ifdef CP_EX_MULH_EN
  assign mul_res = mul_hi ? acc[AW-1:DATA_WIDTH] : acc[DATA_WIDTH-1:0];
`else
  assign mul_res = acc;
`endif

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state <= S_IDLE;
      pred_q <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      count <= '0;
      mul_addr <= '0;
      mul_we <= 1'b0;
`ifdef CP_EX_MULH_EN
      mul_hi <= 1'b0;
`endif
    end else begin
      state <= state_n;
      pred_q <= pred_n;
      if (launch) begin
        acc <= '0;
        mcand <= AW'(iID_EX_MSL_Operand_A);
        mplier <= iID_EX_MSL_Operand_B;
        count <= CW'(K);
        mul_addr <= iID_EX_RF_Write_Addr;
        mul_we <= iID_EX_RF_WriteBack[0];
`ifdef CP_EX_MULH_EN
        mul_hi <= mop[0];
`endif
      end else if (state == S_BUSY) begin
        acc <= acc + partial;
        mcand <= mcand << MUL_BITS_PER_CYCLE;
        mplier <= mplier >> MUL_BITS_PER_CYCLE;
        count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    oEX_ID_Stall = 1'b0;
    oEX_WB_Write_RF_Enable = 1'b0;
    oEX_WB_Write_RF_Address = iID_EX_RF_Write_Addr;
    oEX_WB_Write_RF_Data = wb_mux;
    unique case (state)
      S_IDLE: begin
        if (launch) begin
          state_n = S_BUSY;
          oEX_ID_Stall = 1'b1;
        end else begin
          oEX_WB_Write_RF_Enable = iID_EX_Valid & iID_EX_RF_WriteBack[0];
        end
      end
      S_BUSY: begin
        oEX_ID_Stall = 1'b1;
        if (count == CW'(1)) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
        oEX_WB_Write_RF_Enable = mul_we;
        oEX_WB_Write_RF_Address = mul_addr;
        oEX_WB_Write_RF_Data = mul_res;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cp_ex_param.sv
// tb_cp_ex_param: randomized bench for cp_ex_param with a cycle-level reference model.
// Directed literal cases pin the model; CP_EX_MULH_EN selects the opcode-111 expectation.
module tb_cp_ex_param;

  localparam int K = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid;
  logic [3:0] alu_op;
  logic [31:0] alu_a, alu_b;
  logic [3:0] pmask;
  logic [1:0] csel;
  logic [2:0] msl_op;
  logic [31:0] msl_a, msl_b;
  logic [2:0] wb_ctl;
  logic [4:0] wb_dst;
  logic [29:0] pc;
  logic [31:0] dmem;
  logic stall;
  logic [3:0] pred;
  logic [31:0] wb_data;
  logic [4:0] wb_addr;
  logic wb_en;

  int checks = 0;
  int errors = 0;

  logic obs_stall = 1'b0;
  logic obs_we;
  logic [3:0] obs_pred;
  logic [4:0] obs_addr;
  logic [31:0] obs_data;

  logic [3:0] m_pred = '0;
  logic m_busy = 1'b0;
  int m_wait = 0;
  logic m_we;
  logic [4:0] m_addr;
  logic [31:0] m_res;

  always #5 clk = ~clk;

  cp_ex_param dut (
    .iClk(clk),
    .iReset_n(rst_n),
    .iID_EX_Valid(valid),
    .oEX_ID_Stall(stall),
    .iID_EX_ALU_Opcode(alu_op),
    .iID_EX_ALU_Operand_A(alu_a),
    .iID_EX_ALU_Operand_B(alu_b),
    .iID_EX_Pred_Write_Mask(pmask),
    .iID_EX_CMOV_Pred_Sel(csel),
    .iID_EX_MSL_Opcode(msl_op),
    .iID_EX_MSL_Operand_A(msl_a),
    .iID_EX_MSL_Operand_B(msl_b),
    .iID_EX_RF_WriteBack(wb_ctl),
    .iID_EX_RF_Write_Addr(wb_dst),
    .iID_EX_PC(pc),
    .iDMEM_EX_Data(dmem),
    .oEX_ID_Pred(pred),
    .oEX_WB_Write_RF_Data(wb_data),
    .oEX_WB_Write_RF_Address(wb_addr),
    .oEX_WB_Write_RF_Enable(wb_en)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic cmp_flag(input logic [3:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
    logic l, e;
    e = (a == b);
    l = op[3] ? (a < b) : ($signed(a) < $signed(b));
    case (op[2:0])
      3'd2: return e;
      3'd3: return !e;
      3'd4: return l || e;
      3'd5: return l;
      3'd6: return !l;
      3'd7: return !(l || e);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] alu_m(input logic [3:0] op,
                                       input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] pr, input logic [1:0] s);
    if (op == 4'b1000) return pr[s] ? a : b;
    if (op[2:0] == 3'd0) return a + b;
    if (op[2:0] == 3'd1) return a - b;
    return {31'd0, cmp_flag(op, a, b)};
  endfunction

  function automatic logic [31:0] msl_m(input logic [2:0] op,
                                       input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return a << b[4:0];
      3'd4: return a >> b[4:0];
      3'd5: return $signed(a) >>> b[4:0];
`ifndef CP_EX_MULH_EN
      3'd7: return a & b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
`ifdef CP_EX_MULH_EN
    return op == 3'd6 || op == 3'd7;
`else
    return op == 3'd6;
`endif
  endfunction

  task automatic cycle();
    logic e_stall, e_we, launch;
    logic [4:0] e_addr;
    logic [31:0] e_data, lrv;
    logic [3:0] e_pred;
    logic [63:0] prod;
    @(negedge clk);
    obs_stall = stall;
    obs_we = wb_en;
    obs_pred = pred;
    obs_addr = wb_addr;
    obs_data = wb_data;
    e_stall = 1'b0;
    e_we = 1'b0;
    e_addr = wb_dst;
    e_data = '0;
    e_pred = m_pred;
    launch = 1'b0;
    if (m_busy) begin
      if (m_wait > 0) e_stall = 1'b1;
      else begin
        e_we = m_we;
        e_addr = m_addr;
        e_data = m_res;
      end
    end else if (valid) begin
      if (alu_op[2:1] != 2'b00)
        e_pred = (m_pred & ~pmask) | (pmask & {4{cmp_flag(alu_op, alu_a, alu_b)}});
      lrv = {pc, 2'b00} + 32'd8;
      case (wb_ctl[2:1])
        2'd0: e_data = alu_m(alu_op, alu_a, alu_b, m_pred, csel);
        2'd1: e_data = lrv;
        2'd2: e_data = dmem;
        default: e_data = msl_m(msl_op, msl_a, msl_b);
      endcase
      if (wb_ctl[2:1] == 2'd3 && is_mul(msl_op)) begin
        launch = 1'b1;
        e_stall = 1'b1;
      end else e_we = wb_ctl[0];
    end
    if (rst_n) begin
      chk("stall", 64'(obs_stall), 64'(e_stall));
      chk("wb_en", 64'(obs_we), 64'(e_we));
      chk("pred", 64'(obs_pred), 64'(e_pred));
      if (e_we) begin
        chk("wb_addr", 64'(obs_addr), 64'(e_addr));
        chk("wb_data", 64'(obs_data), 64'(e_data));
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      m_pred = '0;
      m_busy = 1'b0;
      m_wait = 0;
    end else begin
      m_pred = e_pred;
      if (launch) begin
        prod = 64'(msl_a) * 64'(msl_b);
        m_busy = 1'b1;
        m_wait = K;
        m_we = wb_ctl[0];
        m_addr = wb_dst;
        m_res = msl_op[0] ? prod[63:32] : prod[31:0];
      end else if (m_busy) begin
        if (m_wait > 0) m_wait--;
        else m_busy = 1'b0;
      end
    end
    #1;
  endtask

  task automatic clr();
    valid = 1'b0; alu_op = '0; alu_a = '0; alu_b = '0; pmask = '0; csel = '0;
    msl_op = '0; msl_a = '0; msl_b = '0; wb_ctl = '0; wb_dst = '0; pc = '0;
    dmem = '0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 5)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    chk("reset_stall", 64'(obs_stall), 64'd0);
    chk("reset_pred", 64'(obs_pred), 64'd0);
    chk("reset_wb_en", 64'(obs_we), 64'd0);

    clr(); valid = 1; alu_op = 4'b0101; alu_a = 32'hFFFF_FFFF; alu_b = 32'd1;
    pmask = 4'b0001;
    cycle();
    chk("slt_bypass", 64'(obs_pred), 64'h1);
    alu_op = 4'b1101; pmask = 4'b0010;
    cycle();
    chk("ult_bypass", 64'(obs_pred), 64'h1);
    clr();
    cycle();
    chk("pred_reg", 64'(obs_pred), 64'h1);

    clr(); valid = 1; alu_op = 4'b0010; alu_a = 32'd5; alu_b = 32'd5; pmask = 4'b0100;
    cycle();
    clr(); valid = 1; alu_op = 4'b1000; csel = 2'd2; alu_a = 32'h11; alu_b = 32'h22;
    wb_ctl = 3'b001; wb_dst = 5'd4;
    cycle();
    chk("cmov_true", 64'(obs_data), 64'h11);
    clr(); valid = 1; alu_op = 4'b0010; alu_a = 32'd1; alu_b = 32'd2; pmask = 4'b0100;
    cycle();
    clr(); valid = 1; alu_op = 4'b1000; csel = 2'd2; alu_a = 32'h11; alu_b = 32'h22;
    wb_ctl = 3'b001; wb_dst = 5'd4;
    cycle();
    chk("cmov_false", 64'(obs_data), 64'h22);

    clr(); valid = 1; msl_op = 3'd5; msl_a = 32'h8000_0000; msl_b = 32'd4;
    wb_ctl = 3'b111; wb_dst = 5'd3;
    cycle();
    chk("sra", 64'(obs_data), 64'hF800_0000);
    msl_op = 3'd4;
    cycle();
    chk("srl", 64'(obs_data), 64'h0800_0000);
    clr(); valid = 1; wb_ctl = 3'b011; pc = 30'h10; wb_dst = 5'd1;
    cycle();
    chk("lr", 64'(obs_data), 64'h48);

    clr(); valid = 1; msl_op = 3'd6; msl_a = 32'h0001_0003; msl_b = 32'd5;
    wb_ctl = 3'b111; wb_dst = 5'd7;
    n = 0;
    do begin
      cycle();
      if (obs_stall) n++;
    end while (obs_stall && n < 100);
    chk("mul_stall_cycles", 64'(n), 64'd33);
    chk("mul_wb_en", 64'(obs_we), 64'd1);
    chk("mul_wb_addr", 64'(obs_addr), 64'd7);
    chk("mul_wb_data", 64'(obs_data), 64'h0005_000F);

`ifdef CP_EX_MULH_EN
    clr(); valid = 1; msl_op = 3'd7; msl_a = 32'hFFFF_FFFF; msl_b = 32'hFFFF_FFFF;
    wb_ctl = 3'b111; wb_dst = 5'd9;
    n = 0;
    do begin
      cycle();
      if (obs_stall) n++;
    end while (obs_stall && n < 100);
    chk("mulhu_stall_cycles", 64'(n), 64'd33);
    chk("mulhu_data", 64'(obs_data), 64'hFFFF_FFFE);
`else
    clr(); valid = 1; msl_op = 3'd7; msl_a = 32'hF0F0_1234; msl_b = 32'h0FF0_FF00;
    wb_ctl = 3'b111; wb_dst = 5'd9;
    cycle();
    chk("op111_stall", 64'(obs_stall), 64'd0);
    chk("op111_and", 64'(obs_data), 64'h00F0_1200);
`endif

    clr(); valid = 1; alu_op = 4'b0010; pmask = 4'b1000;
    cycle();
    clr(); valid = 1; msl_op = 3'd6; msl_a = 32'd3; msl_b = 32'd3;
    wb_ctl = 3'b111; wb_dst = 5'd2;
    repeat (23) cycle();
    clr();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    chk("abort_stall", 64'(obs_stall), 64'd0);
    chk("abort_pred", 64'(obs_pred), 64'd0);
    chk("abort_wb_en", 64'(obs_we), 64'd0);
    n = 0;
    repeat (40) begin
      cycle();
      if (obs_we) n++;
    end
    chk("abort_no_wb", 64'(n), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom % 600) != 0;
      if (!obs_stall) begin
        valid = ($urandom % 4) != 0;
        alu_op = 4'($urandom);
        alu_a = pick();
        alu_b = ($urandom % 3 == 0) ? alu_a : pick();
        pmask = 4'($urandom);
        csel = 2'($urandom);
        msl_op = 3'($urandom);
        msl_a = pick();
        msl_b = pick();
        wb_ctl = 3'($urandom);
        wb_dst = 5'($urandom);
        pc = 30'($urandom);
        dmem = $urandom;
        if (wb_ctl[2:1] == 2'b11 && msl_op[2:1] == 2'b11 && ($urandom % 4) != 0)
          wb_ctl[2:1] = 2'b10;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp_ex_param.md
# cp_ex_param

Parametrised execution stage for the control-processor pipeline, the next generation of the fixed 32-bit CP EX stage. It performs add/sub/compare/conditional-move, logic and shift in a single cycle. Compare results go to an N-entry predicate file. A multi-cycle iterative multiplier stalls the ID stage with a handshake. It sits between ID and WB and selects the RF write-back data from ALU, link address, DMEM load data or MUL/shift/logic result.

## Interface
- DATA_WIDTH, 32: datapath width; must be a power of two, at least 8.
- PRED_NUM, 4: number of predicate registers; entry 0 is the branch flag.
- RF_INDEX_WIDTH, 5: register-file index width.
- PC_WIDTH, 30: word-addressed PC width.
- MUL_BITS_PER_CYCLE, 1: multiplier bits retired per cycle; must divide DATA_WIDTH. K = DATA_WIDTH/MUL_BITS_PER_CYCLE.
- iClk  in  1  system clock, posedge.
- iReset_n  in  1  reset; synchronous, active-low.
- iID_EX_Valid  in  1  instruction present this cycle.
- oEX_ID_Stall  out  1  ID must hold its outputs.
- iID_EX_ALU_Opcode  in  4  ALU op.
- iID_EX_ALU_Operand_A, iID_EX_ALU_Operand_B  in  DATA_WIDTH each  ALU operands.
- iID_EX_Pred_Write_Mask  in  PRED_NUM  predicates updated by a compare.
- iID_EX_CMOV_Pred_Sel  in  clog2(PRED_NUM)  predicate selecting the CMOV source.
- iID_EX_MSL_Opcode  in  3  MUL/shift/logic op.
- iID_EX_MSL_Operand_A, iID_EX_MSL_Operand_B  in  DATA_WIDTH each  MSL operands.
- iID_EX_RF_WriteBack  in  3  bit0 is write enable; [2:1] source: 00 ALU, 01 LR, 10 LSU, 11 MSL.
- iID_EX_RF_Write_Addr  in  RF_INDEX_WIDTH  destination.
- iID_EX_PC  in  PC_WIDTH  instruction PC.
- iDMEM_EX_Data  in  DATA_WIDTH  load data.
- oEX_ID_Pred  out  PRED_NUM  predicates with same-cycle bypass.
- oEX_WB_Write_RF_Data  out  DATA_WIDTH  write-back data.
- oEX_WB_Write_RF_Address  out  RF_INDEX_WIDTH  write-back index.
- oEX_WB_Write_RF_Enable  out  1  write-back enable.

## Operation
- **ALU opcode map**
  - [2:0]=000 is ADD; 001 is SUB.
  - [2:0]=010..111 are compares: EQ, NE, LE, LT, GE, GT.
  - Bit 3 set on a compare means unsigned; clear means signed.
  - 1000 is CMOV; 1001 behaves as SUB.
  - Compares and SUB use a (DATA_WIDTH+1)-bit extended A + ~B + 1. Bit DATA_WIDTH is the "less-than" bit; the low DATA_WIDTH bits are the sum/zero test.
- **Predicates**
  - A compare with Valid updates every predicate whose mask bit is set.
  - oEX_ID_Pred[i] shows the new value in the same cycle when pred i is being written; otherwise it shows the register.
- **CMOV:** result = Pred[Sel] ? A : B. The register value is used, not the bypass.
- **MSL opcode map**
  - 000 AND, 001 OR, 010 XOR.
  - 011 SLL, 100 SRL, 101 SRA; shift amount is the low clog2(DATA_WIDTH) bits of B.
  - 110 MUL returns the low half. 111 MULHU returns the unsigned high half; see Configuration.
  - Shift operands are AND-isolated when the op is not a shift.
- **LR:** {PC,2'b00}+8, truncated/zero-extended to DATA_WIDTH.
- **Multiplier FSM** (IDLE, BUSY, DONE)
  - IDLE, Valid with MSL opcode 110/111 and write-back source MSL: latch operands, opcode, address and enable; count = K; go to BUSY. Stall is high combinationally in this cycle; WB enable is 0.
  - BUSY: process MUL_BITS_PER_CYCLE bits per cycle. Stall is high; WB enable is 0; ID inputs are ignored. After K cycles go to DONE.
  - DONE: stall is low. WB drives the latched address/result with the latched enable. The held MUL on the ID inputs retires and is not relaunched. Next state is IDLE.
- **Single-cycle ops:** never stall. WB enable = Valid & WriteBack[0].

## Timing
- Reset values:
  - FSM is IDLE; all predicates are 0.
  - oEX_ID_Stall = 0; oEX_WB_Write_RF_Enable = 0; oEX_ID_Pred = 0.
- Reset mid-multiply aborts the multiply: no write-back, no stall from the next cycle.
- ALU, shift, logic, LR and LSU results are combinational (0-cycle) to WB.
- MUL occupies K+2 cycles, with stall high for K+1 of them. The result appears in exactly one DONE cycle.
- Valid=0 means no predicate update, no WB enable and no multiply launch.
- Compares that write predicates and a BUSY multiply cannot overlap, because ID is stalled.

## Configuration
- CP_EX_MULH_EN defined:
  - The accumulator is 2*DATA_WIDTH bits wide.
  - Opcode 111 returns bits [2*DATA_WIDTH-1:DATA_WIDTH] of the unsigned product.
- CP_EX_MULH_EN undefined:
  - The accumulator is DATA_WIDTH bits wide.
  - Opcode 111 executes as single-cycle AND with no stall.

## Test plan
- Hold iReset_n=0 for 2 cycles at BUSY count 10 → next cycle stall=0, Pred=0000, WB enable=0; no write-back afterwards.
- Signed LT (0101), A=0xFFFFFFFF, B=1, mask 0001 → Pred[0]=1 the same cycle. Unsigned LT (1101), mask 0010 → Pred[1]=0. Registered values match one cycle later.
- Pred[2]=1, CMOV with Sel=2, A=0x11, B=0x22 → WB data 0x00000011; then Pred[2]=0 → 0x00000022.
- MUL_BITS_PER_CYCLE=1: MUL 0x00010003×0x00000005 to r7 → stall high 33 cycles, then one cycle WB address 7, data 0x0005000F, enable 1.
- With CP_EX_MULH_EN: MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. Without it: opcode 111 → A&B, no stall.
- SRA 0x80000000 by 4 → 0xF8000000. SRL by 4 → 0x08000000. LR with PC=0x10 → 0x00000048.
